hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline sequencing controller for the 4-stage ID→EXE→DM→WB datapath and the 4×8 main register file. It keeps a per-register scoreboard of in-flight writers and detects read-after-write hazards for the instruction in ID. It generates stall, bubble and issue controls for the IF/ID and ID/EXE stage registers. It also tracks each writer down the pipe and produces the register-file write enable and address in the WB slot.

## Interface
- WB_LAT, 3, cycles from ID issue to the WB slot. Legal range 1..3; the scoreboard counters are 2 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- hold  in  1  external freeze (memory busy); the whole pipeline holds
- flush  in  1  squash the instruction currently in ID (taken branch)
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  2 each  source register indices
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- id_rd  in  2  destination register index
- id_wr  in  1  instruction writes id_rd
- issue  out  1  instruction in ID advances to EXE this cycle
- stall  out  1  hold PC and IF/ID contents
- bubble  out  1  load a NOP into ID/EXE
- wb_we  out  1  register-file write enable, one cycle per writer
- wb_addr  out  2  register-file write index
- busy  out  1  at least one scoreboard entry nonzero
- stall_cnt  out  16  saturating count of hazard-stall cycles

## Operation
- Scoreboard: sb[0..3], 2 bits each. A source has a hazard when its used flag is set and its sb entry is nonzero. hazard = (rs1 hazard) | (rs2 hazard).
- Combinational controls (Mealy, from inputs and current state):
  - issue = id_valid & ~hazard & ~hold & ~flush
  - stall = hold | (id_valid & hazard & ~flush)
  - bubble = ~hold & ~issue
- Scoreboard update on each rising edge where hold=0:
  - Every nonzero entry decrements by 1.
  - If issue & id_wr, sb[id_rd] loads WB_LAT. The load wins over the decrement on the same entry.
  - The hazard check always uses pre-update values. An instruction that reads and writes the same register checks only older writers.
- Writer pipe: a shift register of WB_LAT entries, each {valid, rd}. When hold=0 it advances:
  - Entry 0 <= {issue & id_wr, id_rd}; entry k <= entry k-1.
  - When hold=1, all entries are frozen.
- wb_we and wb_addr are registered from the last pipe entry, so a writer enters WB exactly WB_LAT cycles after issue.
- While hold=1, wb_we deasserts after its first cycle so a held writer is written only once. wb_addr holds its value.
- Back-to-back writers produce wb_we high on consecutive cycles. The register file qualifies wb_we with the clk rising edge.
- stall_cnt increments on cycles where id_valid & hazard & ~hold & ~flush. It saturates at 16'hFFFF and is cleared only by rst.
- busy = OR over all sb entries (combinational).

## Timing
- Reset, asynchronous and immediate:
  - sb all 0; pipe entries invalid; wb_we=0, wb_addr=0, stall_cnt=0.
  - With inputs low, issue=0, stall=0, bubble=1, busy=0.
- Latency, WB_LAT=3, writer issued in cycle t:
  - It occupies the WB slot in cycle t+3; wb_we=1 in t+3 with wb_addr=rd.
  - A dependent reader issues no earlier than cycle t+4, with sb values 3, 2, 1, 0 over cycles t+1 to t+4.
- Dependent reader arriving in cycle t+1: 3 stall cycles, issue in t+4, stall_cnt +3.
- Two writers to the same register in flight: the younger reloads WB_LAT. The reader waits for the younger writer.
- hold: decrements and pipe shifts pause; the total stall extends by the number of hold cycles. Hold cycles are not counted in stall_cnt.
- flush: the ID instruction never issues, and bubble=1 that cycle. Older writers in the pipe continue unaffected.
- hold and flush asserted together: hold dominates, so bubble=0 and stall=1.
- rst mid-operation discards all in-flight writers; no wb_we pulse follows.

## Test plan
- Reset release, then independent writers r0..r3 issued on consecutive cycles -> issue=1 every cycle; wb_we=1 in cycles 3..6 with wb_addr 0, 1, 2, 3; stall_cnt=0.
- Writer to r2 at t, reader (rs1=r2, used) at t+1 -> stall=1 and bubble=1 in t+1..t+3; issue in t+4; stall_cnt=3.
- Same as the previous case with rs1_used=0 -> no stall; reader issues at t+1.
- Writer to r1 at t, hold high in t+1..t+2, dependent reader waiting -> reader issues at t+6; wb_we high for exactly one cycle; stall_cnt=3.
- Writer to r3 at t, second writer to r3 at t+1, reader of r3 at t+2 -> reader issues at t+5; two wb_we pulses, in t+3 and t+4.
- Asynchronous rst asserted while two writers are in flight -> busy=0 and wb_we=0 immediately; no write occurs after reset release.

Source files
------------

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: RAW-hazard scoreboard and writeback sequencing for the
// ID -> EXE -> DM -> WB pipeline driving a 4x8 register file.
module hazard_scheduler #(
    parameter int unsigned WB_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [1:0]  id_rs1,
    input  logic [1:0]  id_rs2,
    input  logic        id_rs1_used,
    input  logic        id_rs2_used,
    input  logic [1:0]  id_rd,
    input  logic        id_wr,
    output logic        issue,
    output logic        stall,
    output logic        bubble,
    output logic        wb_we,
    output logic [1:0]  wb_addr,
    output logic        busy,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] LoadVal = 2'(WB_LAT);

    typedef struct packed {
        logic       valid;
        logic [1:0] rd;
    } wr_entry_t;

    logic [1:0] sb_q   [4];
    logic [1:0] sb_d   [4];
    wr_entry_t  pipe_q [WB_LAT];
    wr_entry_t  pipe_d [WB_LAT];
    logic       hold_q, hold_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic rs1_haz, rs2_haz, hazard, cnt_en;

    // Hazard detection and Mealy pipeline controls from pre-update scoreboard
    always_comb begin
        rs1_haz = id_rs1_used & (sb_q[id_rs1] != 2'd0);
        rs2_haz = id_rs2_used & (sb_q[id_rs2] != 2'd0);
        hazard  = rs1_haz | rs2_haz;
        issue   = id_valid & ~hazard & ~hold & ~flush;
        stall   = hold | (id_valid & hazard & ~flush);
        bubble  = ~hold & ~issue;
        cnt_en  = id_valid & hazard & ~hold & ~flush;
        busy    = (sb_q[0] != 2'd0) | (sb_q[1] != 2'd0) |
                  (sb_q[2] != 2'd0) | (sb_q[3] != 2'd0);
    end

    // Next-state for scoreboard, writer pipe, hold history and stall counter
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sb_d[i] = sb_q[i];
        end
        for (int k = 0; k < int'(WB_LAT); k++) begin
            pipe_d[k] = pipe_q[k];
        end
        hold_d      = hold;
        stall_cnt_d = stall_cnt_q;

        if (!hold) begin
            for (int i = 0; i < 4; i++) begin
                if (sb_q[i] != 2'd0) begin
                    sb_d[i] = sb_q[i] - 2'd1;
                end
            end
            // A fresh writer reloads its entry, overriding the decrement
            if (issue && id_wr) begin
                sb_d[id_rd] = LoadVal;
            end
            pipe_d[0].valid = issue & id_wr;
            pipe_d[0].rd    = id_rd;
            for (int k = 1; k < int'(WB_LAT); k++) begin
                pipe_d[k] = pipe_q[k-1];
            end
        end

        if (cnt_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State registers, asynchronously cleared so in-flight writers are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                sb_q[i] <= 2'd0;
            end
            for (int k = 0; k < int'(WB_LAT); k++) begin
                pipe_q[k] <= '0;
            end
            hold_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sb_q[i] <= sb_d[i];
            end
            for (int k = 0; k < int'(WB_LAT); k++) begin
                pipe_q[k] <= pipe_d[k];
            end
            hold_q      <= hold_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // The last pipe entry is the WB slot. The pipe only moves on edges with
    // hold low, so hold_q set means the slot's writer was already written.
    always_comb begin
        wb_we     = pipe_q[WB_LAT-1].valid & ~hold_q;
        wb_addr   = pipe_q[WB_LAT-1].rd;
        stall_cnt = stall_cnt_q;
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: per-scenario tasks plus a
// writeback scoreboard queue checked by a monitor on every falling edge.
module tb_hazard_scheduler;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        flush;
    logic        id_valid;
    logic [1:0]  id_rs1;
    logic [1:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [1:0]  id_rd;
    logic        id_wr;
    logic        issue;
    logic        stall;
    logic        bubble;
    logic        wb_we;
    logic [1:0]  wb_addr;
    logic        busy;
    logic [15:0] stall_cnt;

    typedef struct {
        int         cyc;
        logic [1:0] addr;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    wb_exp_t mon_e;
    wb_exp_t miss_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_stall = 0;

    hazard_scheduler #(.WB_LAT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_used(id_rs1_used),
        .id_rs2_used(id_rs2_used),
        .id_rd      (id_rd),
        .id_wr      (id_wr),
        .issue      (issue),
        .stall      (stall),
        .bubble     (bubble),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Writeback monitor: every wb_we pulse must match the queue head
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                miss_e = exp_q.pop_front();
                total++;
                bad++;
                $display("FAIL wb_missed: no write seen, required addr=%0d at cyc=%0d (now %0d)",
                         miss_e.addr, miss_e.cyc, cyc);
            end
            if (wb_we === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected: got write addr=%0d at cyc=%0d, required none",
                             wb_addr, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.addr !== wb_addr) begin
                        bad++;
                        $display("FAIL wb_slot: got addr=%0d cyc=%0d, required addr=%0d cyc=%0d",
                                 wb_addr, cyc, mon_e.addr, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        id_rs1      = 2'd0;
        id_rs2      = 2'd0;
        id_rs1_used = 1'b0;
        id_rs2_used = 1'b0;
        id_rd       = 2'd0;
        id_wr       = 1'b0;
    endtask

    task automatic set_id(input logic v, input logic [1:0] rs1, input logic u1,
                          input logic [1:0] rs2, input logic u2,
                          input logic [1:0] rd, input logic wr);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_wr       = wr;
    endtask

    task automatic push_wb(input int c, input logic [1:0] a);
        wb_exp_t e;
        e.cyc  = c;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        idle();
        @(negedge clk);
        total++; if (issue !== 1'b0) begin bad++; $display("FAIL reset_issue got=%b want=0", issue); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        total++; if (bubble !== 1'b1) begin bad++; $display("FAIL reset_bubble got=%b want=1", bubble); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL reset_wb_we got=%b want=0", wb_we); end
        total++; if (wb_addr !== 2'd0) begin bad++; $display("FAIL reset_wb_addr got=%0d want=0", wb_addr); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d want=0", stall_cnt); end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_indep_writers();
        for (int i = 0; i < 4; i++) begin
            set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'(i), 1'b1);
            @(negedge clk);
            total++;
            if (issue !== 1'b1 || stall !== 1'b0) begin
                bad++;
                $display("FAIL indep_issue r%0d got issue=%b stall=%b want issue=1 stall=0",
                         i, issue, stall);
            end
            push_wb(cyc + 3, 2'(i));
            next_cycle();
        end
        idle();
        repeat (4) next_cycle();
        @(negedge clk);
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL indep_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL indep_busy_idle got=%b want=0", busy); end
        next_cycle();
    endtask

    task automatic test_raw_stall();
        set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1);
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL raw_writer_issue got=%b want=1", issue); end
        push_wb(cyc + 3, 2'd2);
        next_cycle();
        set_id(1'b1, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            total++;
            if (issue !== 1'b0 || stall !== 1'b1 || bubble !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL raw_stall t+%0d got issue=%b stall=%b bubble=%b busy=%b want 0/1/1/1",
                         k, issue, stall, bubble, busy);
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (issue !== 1'b1 || stall !== 1'b0 || bubble !== 1'b0) begin
            bad++;
            $display("FAIL raw_reader_issue got issue=%b stall=%b bubble=%b want 1/0/0",
                     issue, stall, bubble);
        end
        exp_stall += 3;
        next_cycle();
        idle();
        next_cycle();
        @(negedge clk);
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL raw_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
        next_cycle();
    endtask

    task automatic test_unused_src();
        set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1);
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL unused_writer_issue got=%b want=1", issue); end
        push_wb(cyc + 3, 2'd2);
        next_cycle();
        // rs1 names the busy register but is not read
        set_id(1'b1, 2'd2, 1'b0, 2'd1, 1'b1, 2'd0, 1'b0);
        @(negedge clk);
        total++;
        if (issue !== 1'b1 || stall !== 1'b0 || bubble !== 1'b0) begin
            bad++;
            $display("FAIL unused_rs1 got issue=%b stall=%b bubble=%b want 1/0/0", issue, stall, bubble);
        end
        next_cycle();
        // rs2 reads the busy register
        set_id(1'b1, 2'd0, 1'b0, 2'd2, 1'b1, 2'd0, 1'b0);
        @(negedge clk);
        total++;
        if (issue !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL rs2_hazard got issue=%b stall=%b want 0/1", issue, stall);
        end
        exp_stall += 1;
        next_cycle();
        idle();
        repeat (4) next_cycle();
        @(negedge clk);
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL unused_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
        next_cycle();
    endtask

    task automatic test_hold();
        set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1);
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL hold_writer_issue got=%b want=1", issue); end
        push_wb(cyc + 5, 2'd1);
        next_cycle();
        set_id(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        hold = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            total++;
            if (issue !== 1'b0 || stall !== 1'b1 || bubble !== 1'b0) begin
                bad++;
                $display("FAIL hold_freeze t+%0d got issue=%b stall=%b bubble=%b want 0/1/0",
                         k, issue, stall, bubble);
            end
            next_cycle();
        end
        hold = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            total++;
            if (issue !== 1'b0 || stall !== 1'b1 || bubble !== 1'b1) begin
                bad++;
                $display("FAIL hold_stall t+%0d got issue=%b stall=%b bubble=%b want 0/1/1",
                         k, issue, stall, bubble);
            end
            next_cycle();
        end
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL hold_reader_issue t+6 got=%b want=1", issue); end
        exp_stall += 3;
        next_cycle();
        idle();
        repeat (3) next_cycle();
        @(negedge clk);
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL hold_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
        next_cycle();
    endtask

    task automatic test_hold_in_wb();
        set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b1);
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL holdwb_writer_issue got=%b want=1", issue); end
        push_wb(cyc + 3, 2'd3);
        next_cycle();
        idle();
        repeat (2) next_cycle();
        // Writer sits in WB; hold and flush together with a fresh writer in ID
        hold  = 1'b1;
        flush = 1'b1;
        set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1);
        @(negedge clk);
        total++;
        if (issue !== 1'b0 || stall !== 1'b1 || bubble !== 1'b0) begin
            bad++;
            $display("FAIL hold_flush got issue=%b stall=%b bubble=%b want 0/1/0", issue, stall, bubble);
        end
        total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL holdwb_first got wb_we=%b want=1", wb_we); end
        next_cycle();
        @(negedge clk);
        total++;
        if (wb_we !== 1'b0 || wb_addr !== 2'd3) begin
            bad++;
            $display("FAIL holdwb_second got wb_we=%b wb_addr=%0d want 0/3", wb_we, wb_addr);
        end
        next_cycle();
        hold  = 1'b0;
        flush = 1'b0;
        idle();
        repeat (4) next_cycle();
    endtask

    task automatic test_flush();
        set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1);
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL flush_writer_issue got=%b want=1", issue); end
        push_wb(cyc + 3, 2'd1);
        next_cycle();
        flush = 1'b1;
        set_id(1'b1, 2'd1, 1'b1, 2'd0, 1'b0, 2'd2, 1'b1);
        @(negedge clk);
        total++;
        if (issue !== 1'b0 || bubble !== 1'b1 || stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_squash got issue=%b bubble=%b stall=%b want 0/1/0", issue, bubble, stall);
        end
        next_cycle();
        flush = 1'b0;
        idle();
        repeat (4) next_cycle();
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL flush_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b1);
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL b2b_first_issue got=%b want=1", issue); end
        push_wb(cyc + 3, 2'd3);
        next_cycle();
        set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd3, 1'b1);
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL b2b_second_issue got=%b want=1", issue); end
        push_wb(cyc + 3, 2'd3);
        next_cycle();
        set_id(1'b1, 2'd0, 1'b0, 2'd3, 1'b1, 2'd0, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (issue !== 1'b0 || stall !== 1'b1) begin
                bad++;
                $display("FAIL b2b_stall t+%0d got issue=%b stall=%b want 0/1", k, issue, stall);
            end
            next_cycle();
        end
        @(negedge clk);
        total++; if (issue !== 1'b1) begin bad++; $display("FAIL b2b_reader_issue t+5 got=%b want=1", issue); end
        exp_stall += 3;
        next_cycle();
        idle();
        repeat (3) next_cycle();
        @(negedge clk);
        total++; if (stall_cnt !== 16'(exp_stall)) begin bad++; $display("FAIL b2b_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
        next_cycle();
    endtask

    task automatic test_rst_midflight();
        set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        next_cycle();
        set_id(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1);
        next_cycle();
        idle();
        #2;
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", busy); end
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL rst_mid_wb_we got=%b want=0", wb_we); end
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_stall_cnt got=%0d want=0", stall_cnt); end
        total++; if (bubble !== 1'b1) begin bad++; $display("FAIL rst_mid_bubble got=%b want=1", bubble); end
        exp_stall = 0;
        next_cycle();
        rst = 1'b0;
        repeat (6) next_cycle();
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_after_busy got=%b want=0", busy); end
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        flush = 1'b0;
        idle();
        test_reset();
        test_indep_writers();
        test_raw_stall();
        test_unused_src();
        test_hold();
        test_hold_in_wb();
        test_flush();
        test_back_to_back();
        test_rst_midflight();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL wb_pending got %0d writes outstanding, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
